fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 32-bit, 4-deep word FIFO.
- Used as a general buffer between the SDRAM controller datapath and the host/bus side.
- Adds over its predecessor:
  - configurable width and depth
  - occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
  - selectable output mode: registered read or first-word-fall-through

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (rdata valid cycle after pop); 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents; error flags preserved
write_enable  in  1  push request
wdata  in  WIDTH  push data
read_enable  in  1  pop request
rdata  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: push attempted while full and not popping
underflow  out  1  sticky: pop attempted while empty
err_clear  in  1  clears overflow/underflow next edge

Behaviour:
- Reset values (rst=1 at an edge):
  - wptr=rptr=0, count=0, rdata=0
  - empty=1, full=0, almost_empty=1
  - almost_full=(AF_LEVEL==0)
  - overflow=underflow=0
  - Storage contents are not reset.
- Reset mid-operation discards all entries; there is no partial state.
- Accept rules, evaluated on the same edge:
  - push_ok = write_enable & (!full | pop_ok)
  - pop_ok = read_enable & !empty
- Pointers:
  - Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
  - Occupancy is tracked by an explicit count register, never by pointer difference.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags are derived combinationally from the count register, so they update in the same cycle count changes.
- Simultaneous push and pop:
  - When full, both are accepted; full stays 1.
  - When empty, only the push is accepted; the pop is rejected and sets underflow.
- Rejected push (write_enable & full & !pop_ok):
  - data dropped, contents unchanged, overflow <= 1
- Rejected pop (read_enable & empty):
  - pointers unchanged, underflow <= 1
  - FWFT=0: rdata holds its previous value.
- Error flags:
  - err_clear=1 clears both flags.
  - If an error event occurs in the same cycle as err_clear, the flag is set; set wins.
- flush=1:
  - pointers and count go to 0, rdata=0 in FWFT=0 mode
  - error flags untouched
  - a simultaneous push or pop is ignored
  - rst has priority over flush.
- FWFT=0: on pop_ok, rdata <= mem[rptr] at that edge, giving one-cycle latency; otherwise rdata holds.
- FWFT=1:
  - rdata = mem[rptr] combinationally; the value is undefined/don't-care while empty.
  - The first word is visible the cycle after its push edge, when empty falls.
  - pop_ok advances to the next word at the edge.
- Write-then-read of the same slot in one cycle cannot occur, because pop requires !empty.

Decomposition:
- Package fifo_pkg:
  - localparam helper function for count/pointer widths
  - typedef for FWFT mode constants (FIFO_REG=0, FIFO_FWFT=1)
- Sub-module fifo_ram:
  - DEPTH x WIDTH register file
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
- Top-level fifo_param holds:
  - pointers and count
  - flags and error logic
  - output register (FWFT=0) or direct read path (FWFT=1)

Test Plan:
1. Fill/drain, WIDTH=32, DEPTH=4, FWFT=0:
   - Reset, push 1,2,3,4 → empty=0 after the first edge, full=1 and count=4 after the fourth.
   - Pop four times → rdata=1,2,3,4 on successive cycles after each pop edge; empty=1 at the end.
2. Overflow and underflow:
   - Full FIFO, push 9 → overflow=1, count=4, subsequent pops still return 1..4.
   - Pop on empty → underflow=1, rdata holds 4.
   - err_clear → both flags 0.
3. Streaming with wrap-around, DEPTH=4:
   - Push 1..10 while popping from the second cycle on → rdata sequence 1..10 with no gaps.
   - count never exceeds 2; pointers wrap at least twice.
4. Full simultaneous push and pop:
   - Full with 1..4; push 5 and pop in the same cycle → count stays 4, full=1, rdata=1.
   - Drain → 2,3,4,5.
5. Thresholds and flush, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2:
   - Push 6 → almost_full=1 at count 6, almost_empty=0 at count 3.
   - flush → count=0, empty=1, almost_empty=1; pre-set overflow remains 1.
6. FWFT=1:
   - Push 0xA5 → next cycle empty=0 and rdata=0xA5 with no pop.
   - Pop while pushing 0x5A → rdata=0x5A next cycle.
   - Assert rst mid-stream → empty=1, count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and output-mode constants for the parametrised FIFO
package fifo_pkg;

  typedef enum logic {
    FIFO_REG  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - push/pop, status and error bundle of the parametrised FIFO
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();
  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             write_enable;
  logic [WIDTH-1:0] wdata;
  logic             read_enable;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             err_clear;

  modport master (
    output flush, write_enable, wdata, read_enable, err_clear,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, write_enable, wdata, read_enable, err_clear,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH register file, synchronous write, asynchronous read
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with occupancy flags, sticky errors,
// flush and selectable registered / first-word-fall-through read path
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic             ovf_event;
  logic             unf_event;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign pop_ok    = bus.read_enable & ~empty;
  assign push_ok   = bus.write_enable & (~full | pop_ok);
  // a flush swallows the cycle's push/pop, so it cannot raise an error either
  assign ovf_event = bus.write_enable & full & ~pop_ok & ~bus.flush;
  assign unf_event = bus.read_enable & empty & ~bus.flush;
  assign ram_we    = push_ok & ~bus.flush & ~rst;

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr),
    .wdata(bus.wdata),
    .raddr(rptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      if (push_ok & ~pop_ok) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop_ok & ~push_ok) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // set wins over err_clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  & ~bus.err_clear) | ovf_event;
      underflow_q <= (underflow_q & ~bus.err_clear) | unf_event;
    end
  end

  generate
    if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
      assign bus.rdata = ram_rdata;
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (bus.flush) begin
          rdata_q <= '0;
        end else if (pop_ok) begin
          rdata_q <= ram_rdata;
        end
      end
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
  assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param: registered, threshold and FWFT builds
module tb_fifo_param;
  import fifo_pkg::*;

  logic tb_clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_rd;
  logic        m_ovf;
  logic        m_unf;

  always #5 tb_clk = ~tb_clk;

  fifo_param_if #(.WIDTH(32), .DEPTH(4)) if_a ();
  fifo_param_if #(.WIDTH(32), .DEPTH(8)) if_b ();
  fifo_param_if #(.WIDTH(32), .DEPTH(4)) if_c ();

  fifo_param #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_dut_a (
    .clk(tb_clk), .rst(rst), .bus(if_a)
  );
  fifo_param #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut_b (
    .clk(tb_clk), .rst(rst), .bus(if_b)
  );
  fifo_param #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_dut_c (
    .clk(tb_clk), .rst(rst), .bus(if_c)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.write_enable = 0; if_a.read_enable = 0; if_a.flush = 0; if_a.err_clear = 0; if_a.wdata = '0;
    if_b.write_enable = 0; if_b.read_enable = 0; if_b.flush = 0; if_b.err_clear = 0; if_b.wdata = '0;
    if_c.write_enable = 0; if_c.read_enable = 0; if_c.flush = 0; if_c.err_clear = 0; if_c.wdata = '0;
  endtask

  task automatic drive_a(input logic we, input logic [31:0] wd, input logic re);
    if_a.write_enable = we;
    if_a.wdata        = wd;
    if_a.read_enable  = re;
    tick();
    if_a.write_enable = 0;
    if_a.read_enable  = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if_a.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", if_a.count); end
    total++; if ({if_a.empty, if_a.full, if_a.almost_empty, if_a.almost_full} !== 4'b1010) begin
      bad++; $display("FAIL reset_flags got=%b want=1010", {if_a.empty, if_a.full, if_a.almost_empty, if_a.almost_full}); end
    total++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin
      bad++; $display("FAIL reset_err got=%b want=00", {if_a.overflow, if_a.underflow}); end
    total++; if (if_a.rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", if_a.rdata); end
    total++; if (if_b.count !== 4'd0 || if_b.empty !== 1'b1) begin
      bad++; $display("FAIL reset_b got count=%0d empty=%b want 0/1", if_b.count, if_b.empty); end
    total++; if (if_c.count !== 3'd0 || if_c.empty !== 1'b1) begin
      bad++; $display("FAIL reset_c got count=%0d empty=%b want 0/1", if_c.count, if_c.empty); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 32'(i), 1'b0);
      total++; if (if_a.count !== 3'(i) || if_a.empty !== 1'b0) begin
        bad++; $display("FAIL fill_count%0d got=%0d empty=%b want=%0d empty=0", i, if_a.count, if_a.empty, i); end
      total++; if (if_a.full !== (i == 4)) begin
        bad++; $display("FAIL fill_full%0d got=%b want=%b", i, if_a.full, (i == 4)); end
    end
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b0, '0, 1'b1);
      total++; if (if_a.rdata !== 32'(i)) begin
        bad++; $display("FAIL drain_rdata%0d got=%0d want=%0d", i, if_a.rdata, i); end
    end
    total++; if (if_a.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", if_a.empty); end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 1; i <= 4; i++) drive_a(1'b1, 32'(i), 1'b0);
    drive_a(1'b1, 32'd9, 1'b0);
    total++; if (if_a.overflow !== 1'b1 || if_a.count !== 3'd4 || if_a.full !== 1'b1) begin
      bad++; $display("FAIL ovf_set got ovf=%b count=%0d full=%b want 1/4/1", if_a.overflow, if_a.count, if_a.full); end
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b0, '0, 1'b1);
      total++; if (if_a.rdata !== 32'(i)) begin
        bad++; $display("FAIL ovf_drain%0d got=%0d want=%0d", i, if_a.rdata, i); end
    end
    drive_a(1'b0, '0, 1'b1);
    total++; if (if_a.underflow !== 1'b1 || if_a.rdata !== 32'd4) begin
      bad++; $display("FAIL unf_set got unf=%b rdata=%0d want 1/4", if_a.underflow, if_a.rdata); end
    if_a.err_clear = 1; tick(); if_a.err_clear = 0;
    total++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin
      bad++; $display("FAIL err_clear got=%b want=00", {if_a.overflow, if_a.underflow}); end
    if_a.err_clear = 1; drive_a(1'b0, '0, 1'b1); if_a.err_clear = 0;
    total++; if (if_a.underflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b want=1", if_a.underflow); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      drive_a(k < 10, 32'(k + 1), k >= 1);
      if (k >= 1) begin
        total++; if (if_a.rdata !== 32'(k)) begin
          bad++; $display("FAIL stream_rdata%0d got=%0d want=%0d", k, if_a.rdata, k); end
      end
      total++; if (if_a.count > 3'd2) begin bad++; $display("FAIL stream_count%0d got=%0d want<=2", k, if_a.count); end
    end
    total++; if (if_a.empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b want=1", if_a.empty); end
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 1; i <= 4; i++) drive_a(1'b1, 32'(i), 1'b0);
    drive_a(1'b1, 32'd5, 1'b1);
    total++; if (if_a.count !== 3'd4 || if_a.full !== 1'b1 || if_a.rdata !== 32'd1) begin
      bad++; $display("FAIL full_pushpop got count=%0d full=%b rdata=%0d want 4/1/1", if_a.count, if_a.full, if_a.rdata); end
    total++; if (if_a.overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b want=0", if_a.overflow); end
    for (int i = 2; i <= 5; i++) begin
      drive_a(1'b0, '0, 1'b1);
      total++; if (if_a.rdata !== 32'(i)) begin
        bad++; $display("FAIL full_drain%0d got=%0d want=%0d", i, if_a.rdata, i); end
    end
  endtask

  task automatic test_thresholds_flush();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      if_b.write_enable = 1; if_b.wdata = 32'(i); tick(); if_b.write_enable = 0;
      total++; if (if_b.almost_full !== (i >= 6) || if_b.almost_empty !== (i <= 2)) begin
        bad++; $display("FAIL thresh%0d got af=%b ae=%b want af=%b ae=%b", i, if_b.almost_full,
                        if_b.almost_empty, (i >= 6), (i <= 2)); end
    end
    if_b.write_enable = 1; if_b.wdata = 32'd99; tick(); if_b.write_enable = 0;
    total++; if (if_b.overflow !== 1'b1 || if_b.count !== 4'd8) begin
      bad++; $display("FAIL b_ovf got ovf=%b count=%0d want 1/8", if_b.overflow, if_b.count); end
    if_b.flush = 1; if_b.write_enable = 1; if_b.read_enable = 1; tick();
    if_b.flush = 0; if_b.write_enable = 0; if_b.read_enable = 0;
    total++; if (if_b.count !== 4'd0 || if_b.empty !== 1'b1 || if_b.almost_empty !== 1'b1) begin
      bad++; $display("FAIL flush_state got count=%0d empty=%b ae=%b want 0/1/1", if_b.count, if_b.empty, if_b.almost_empty); end
    total++; if (if_b.overflow !== 1'b1 || if_b.underflow !== 1'b0 || if_b.rdata !== 32'd0) begin
      bad++; $display("FAIL flush_err got ovf=%b unf=%b rdata=%0d want 1/0/0", if_b.overflow, if_b.underflow, if_b.rdata); end
  endtask

  task automatic test_fwft();
    do_reset();
    if_c.write_enable = 1; if_c.wdata = 32'hA5; tick(); if_c.write_enable = 0;
    total++; if (if_c.empty !== 1'b0 || if_c.rdata !== 32'hA5) begin
      bad++; $display("FAIL fwft_first got empty=%b rdata=%0h want 0/a5", if_c.empty, if_c.rdata); end
    if_c.write_enable = 1; if_c.wdata = 32'h5A; if_c.read_enable = 1; tick();
    if_c.write_enable = 0; if_c.read_enable = 0;
    total++; if (if_c.rdata !== 32'h5A || if_c.count !== 3'd1) begin
      bad++; $display("FAIL fwft_next got rdata=%0h count=%0d want 5a/1", if_c.rdata, if_c.count); end
    if_c.write_enable = 1; if_c.wdata = 32'h11; tick();
    rst = 1; tick(); rst = 0; if_c.write_enable = 0;
    total++; if (if_c.empty !== 1'b1 || if_c.count !== 3'd0) begin
      bad++; $display("FAIL fwft_rst got empty=%b count=%0d want 1/0", if_c.empty, if_c.count); end
  endtask

  // A (registered) and C (FWFT) share stimulus and one queue-based model
  task automatic test_random();
    logic we, re, fl, ec, pop, push, was_full, was_empty;
    logic [31:0] wd;
    do_reset();
    m_q.delete(); m_rd = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      ec = ($urandom_range(0, 99) < 5);
      wd = $urandom;
      if_a.write_enable = we; if_a.read_enable = re; if_a.flush = fl; if_a.err_clear = ec; if_a.wdata = wd;
      if_c.write_enable = we; if_c.read_enable = re; if_c.flush = fl; if_c.err_clear = ec; if_c.wdata = wd;
      tick();
      was_full  = (m_q.size() == 4);
      was_empty = (m_q.size() == 0);
      pop  = re && !was_empty;
      push = we && (!was_full || pop);
      if (ec) begin m_ovf = 0; m_unf = 0; end
      if (fl) begin
        m_q.delete(); m_rd = 0;
      end else begin
        if (we && was_full && !pop) m_ovf = 1;
        if (re && was_empty) m_unf = 1;
        if (pop) m_rd = m_q.pop_front();
        if (push) m_q.push_back(wd);
      end
      total++; if (if_a.count !== 3'(m_q.size()) || if_a.rdata !== m_rd) begin
        bad++; $display("FAIL rand_a%0d got count=%0d rdata=%0h want %0d/%0h", n, if_a.count, if_a.rdata, m_q.size(), m_rd); end
      total++; if ({if_a.full, if_a.empty, if_a.almost_full, if_a.almost_empty, if_a.overflow, if_a.underflow} !==
                   {m_q.size() == 4, m_q.size() == 0, m_q.size() >= 3, m_q.size() <= 1, m_ovf, m_unf}) begin
        bad++; $display("FAIL rand_flags%0d got=%b want=%b", n,
          {if_a.full, if_a.empty, if_a.almost_full, if_a.almost_empty, if_a.overflow, if_a.underflow},
          {m_q.size() == 4, m_q.size() == 0, m_q.size() >= 3, m_q.size() <= 1, m_ovf, m_unf}); end
      total++; if (if_c.count !== 3'(m_q.size()) || {if_c.overflow, if_c.underflow} !== {m_ovf, m_unf}) begin
        bad++; $display("FAIL rand_c%0d got count=%0d err=%b want %0d/%b", n, if_c.count,
                        {if_c.overflow, if_c.underflow}, m_q.size(), {m_ovf, m_unf}); end
      if (m_q.size() > 0) begin
        total++; if (if_c.rdata !== m_q[0]) begin
          bad++; $display("FAIL rand_fwft%0d got=%0h want=%0h", n, if_c.rdata, m_q[0]); end
      end
    end
    idle_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle_all();
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_stream();
    test_back_to_back_full();
    test_thresholds_flush();
    test_fwft();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
